// File: rtl/dgs_pkg.sv
// Shared definitions for the dual grant scheduler.
//   N_REQ     : number of requesters (12 in this revision)
//   IDX_W     : width of a 1-based grant index (0 means "no grant")
//   idx_t     : grant index type
//   req_vec_t : one bit per requester
//   onehot_of : converts a 1-based index into its requester bit (0 -> all zeros)
package dgs_pkg;

  localparam int N_REQ = 12;
  localparam int IDX_W = 4;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_REQ-1:0] req_vec_t;

  // Index 0 means "nothing loaded", so it maps to an empty mask.
  function automatic req_vec_t onehot_of(input idx_t idx);
    req_vec_t vec;
    vec = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (idx == idx_t'(k + 1)) vec[k] = 1'b1;
    end
    return vec;
  endfunction

endpackage

// File: rtl/dual_grant_scheduler_pick.sv
// Combinational dual priority encoder.
//   req_vec    in  : pending request vector
//   first_idx  out : highest set bit + 1, or 0 if no bit is set
//   second_idx out : next-highest set bit + 1, or 0 if fewer than two bits are set
module dual_pick
  import dgs_pkg::*;
(
  input  req_vec_t req_vec,
  output idx_t     first_idx,
  output idx_t     second_idx
);

  // Scanning upward, each newly found set bit becomes the leader and the
  // previous leader slides down to second place, so the final values are
  // the two highest set bits.
  always_comb begin
    first_idx  = '0;
    second_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (req_vec[k]) begin
        second_idx = first_idx;
        first_idx  = idx_t'(k + 1);
      end
    end
  end

endmodule

// File: rtl/dual_grant_scheduler.sv
// Dual grant scheduler: collects request pulses into a sticky pending
// register and issues the two highest-priority pending requests on two
// registered valid/ready grant channels.
//   clk_i        in  : clock, rising edge
//   rst_ni       in  : asynchronous active-low reset
//   req_pulse_i  in  : request pulses, bit k sets pending[k]
//   gnt0_valid_o out : slot 0 holds a grant
//   gnt0_idx_o   out : slot 0 index (1..12), 0 when invalid
//   gnt0_ready_i in  : consumer 0 accepts slot 0
//   gnt1_valid_o out : slot 1 holds a grant
//   gnt1_idx_o   out : slot 1 index (1..12), 0 when invalid
//   gnt1_ready_i in  : consumer 1 accepts slot 1
//   pending_o    out : registered pending vector
//   busy_o       out : anything pending or any slot valid
module dual_grant_scheduler
  import dgs_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_pulse_i,
  output logic             gnt0_valid_o,
  output logic [IDX_W-1:0] gnt0_idx_o,
  input  logic             gnt0_ready_i,
  output logic             gnt1_valid_o,
  output logic [IDX_W-1:0] gnt1_idx_o,
  input  logic             gnt1_ready_i,
  output logic [N_REQ-1:0] pending_o,
  output logic             busy_o
);

  req_vec_t pending_q;
  req_vec_t pending_d;
  req_vec_t load_mask;
  idx_t     first_idx;
  idx_t     second_idx;
  idx_t     load0_idx;
  idx_t     load1_idx;
  logic     gnt0_valid_q;
  logic     gnt1_valid_q;
  idx_t     gnt0_idx_q;
  idx_t     gnt1_idx_q;
  logic     slot0_free;
  logic     slot1_free;

  dual_pick u_pick (
    .req_vec    (pending_q),
    .first_idx  (first_idx),
    .second_idx (second_idx)
  );

  // A slot can take a new grant when empty or when its current grant is
  // being handed off this cycle.
  assign slot0_free = !gnt0_valid_q || gnt0_ready_i;
  assign slot1_free = !gnt1_valid_q || gnt1_ready_i;

  // Load selection: the best pending request always goes to the lowest
  // free slot; the runner-up is only used when both slots are free. Only
  // indices actually loaded are cleared, and a new pulse on the same bit
  // re-arms it because the OR comes after the clear.
  always_comb begin
    load0_idx = '0;
    load1_idx = '0;
    if (slot0_free && slot1_free) begin
      load0_idx = first_idx;
      load1_idx = second_idx;
    end else if (slot0_free) begin
      load0_idx = first_idx;
    end else if (slot1_free) begin
      load1_idx = first_idx;
    end
    load_mask = onehot_of(load0_idx) | onehot_of(load1_idx);
    pending_d = (pending_q & ~load_mask) | req_pulse_i;
  end

  // Pending and slot registers. A free slot always reloads, so loading
  // index 0 naturally empties it; a stalled slot keeps its contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q    <= '0;
      gnt0_valid_q <= 1'b0;
      gnt0_idx_q   <= '0;
      gnt1_valid_q <= 1'b0;
      gnt1_idx_q   <= '0;
    end else begin
      pending_q <= pending_d;
      if (slot0_free) begin
        gnt0_valid_q <= (load0_idx != '0);
        gnt0_idx_q   <= load0_idx;
      end
      if (slot1_free) begin
        gnt1_valid_q <= (load1_idx != '0);
        gnt1_idx_q   <= load1_idx;
      end
    end
  end

  assign gnt0_valid_o = gnt0_valid_q;
  assign gnt0_idx_o   = gnt0_idx_q;
  assign gnt1_valid_o = gnt1_valid_q;
  assign gnt1_idx_o   = gnt1_idx_q;
  assign pending_o    = pending_q;
  assign busy_o       = (|pending_q) || gnt0_valid_q || gnt1_valid_q;

endmodule

// File: tb/tb_dual_grant_scheduler.sv
// Self-checking bench for dual_grant_scheduler. A behavioural model of the
// pending register and both slots runs alongside the DUT; every grant the
// model loads is queued per slot and popped when the DUT hands one off.
module tb_dual_grant_scheduler;

  logic        clk_i;
  logic        rst_ni;
  logic [11:0] req_pulse_i;
  logic        gnt0_valid_o;
  logic [3:0]  gnt0_idx_o;
  logic        gnt0_ready_i;
  logic        gnt1_valid_o;
  logic [3:0]  gnt1_idx_o;
  logic        gnt1_ready_i;
  logic [11:0] pending_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [11:0] m_pend;
  bit          m_v0, m_v1;
  int          m_i0, m_i1;
  int          q0[$];
  int          q1[$];
  int          grants;
  int          newReqs;

  dual_grant_scheduler dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_pulse_i  (req_pulse_i),
    .gnt0_valid_o (gnt0_valid_o),
    .gnt0_idx_o   (gnt0_idx_o),
    .gnt0_ready_i (gnt0_ready_i),
    .gnt1_valid_o (gnt1_valid_o),
    .gnt1_idx_o   (gnt1_idx_o),
    .gnt1_ready_i (gnt1_ready_i),
    .pending_o    (pending_o),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Highest and next-highest set bit (1-based), scanning from the top down.
  task automatic topTwo(input logic [11:0] v, output int f, output int s);
    f = 0;
    s = 0;
    for (int k = 11; k >= 0; k--) begin
      if (v[k]) begin
        if (f == 0) f = k + 1;
        else if (s == 0) s = k + 1;
      end
    end
  endtask

  function automatic logic [11:0] bitOf(input int i);
    logic [11:0] m;
    m = '0;
    if (i > 0) m[i-1] = 1'b1;
    return m;
  endfunction

  task automatic applyReset();
    rst_ni       = 1'b0;
    req_pulse_i  = '0;
    gnt0_ready_i = 1'b0;
    gnt1_ready_i = 1'b0;
    #1;
    m_pend = '0; m_v0 = 0; m_v1 = 0; m_i0 = 0; m_i1 = 0;
    q0.delete(); q1.delete();
    grants = 0; newReqs = 0;
    checkOutput("rst_valid0", gnt0_valid_o, 0);
    checkOutput("rst_idx0", gnt0_idx_o, 0);
    checkOutput("rst_valid1", gnt1_valid_o, 0);
    checkOutput("rst_idx1", gnt1_idx_o, 0);
    checkOutput("rst_pending", pending_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  // Drives one cycle of stimulus, advances the model and scoreboard, then
  // compares the DUT state just after the clock edge.
  task automatic applyStimulus(input logic [11:0] pulse, input logic r0, input logic r1);
    int f, s, l0, l1, exp;
    logic f0, f1, stall0, stall1;
    logic [3:0] held0, held1;
    logic [11:0] mask;
    if (m_v0 && r0) begin
      grants++;
      if (q0.size() > 0) exp = q0.pop_front(); else exp = -1;
      checkOutput("sb_slot0", gnt0_idx_o, exp);
    end
    if (m_v1 && r1) begin
      grants++;
      if (q1.size() > 0) exp = q1.pop_front(); else exp = -1;
      checkOutput("sb_slot1", gnt1_idx_o, exp);
    end
    stall0 = gnt0_valid_o && !r0; held0 = gnt0_idx_o;
    stall1 = gnt1_valid_o && !r1; held1 = gnt1_idx_o;
    req_pulse_i  = pulse;
    gnt0_ready_i = r0;
    gnt1_ready_i = r1;
    f0 = !m_v0 || r0;
    f1 = !m_v1 || r1;
    topTwo(m_pend, f, s);
    l0 = 0; l1 = 0;
    if (f0 && f1) begin l0 = f; l1 = s; end
    else if (f0) l0 = f;
    else if (f1) l1 = f;
    mask = bitOf(l0) | bitOf(l1);
    newReqs += $countones(pulse & ~(m_pend & ~mask));
    m_pend = (m_pend & ~mask) | pulse;
    if (f0) begin m_v0 = (l0 != 0); m_i0 = l0; if (l0 != 0) q0.push_back(l0); end
    if (f1) begin m_v1 = (l1 != 0); m_i1 = l1; if (l1 != 0) q1.push_back(l1); end
    @(posedge clk_i); #1;
    req_pulse_i = '0;
    checkOutput("valid0", gnt0_valid_o, m_v0);
    checkOutput("idx0", gnt0_idx_o, m_i0);
    checkOutput("valid1", gnt1_valid_o, m_v1);
    checkOutput("idx1", gnt1_idx_o, m_i1);
    checkOutput("pending", pending_o, m_pend);
    checkOutput("busy", busy_o, (m_pend != 0) || m_v0 || m_v1);
    if (stall0) checkOutput("stall0_idx", gnt0_idx_o, held0);
    if (stall1) checkOutput("stall1_idx", gnt1_idx_o, held1);
    if (l0 != 0 && l1 != 0) checkOutput("order", gnt0_idx_o > gnt1_idx_o, 1);
  endtask

  initial begin
    rst_ni       = 1'b1;
    req_pulse_i  = '0;
    gnt0_ready_i = 1'b0;
    gnt1_ready_i = 1'b0;
    #2;
    applyReset();

    // Idle after reset
    $display("[TB] idle after reset");
    for (int i = 0; i < 20; i++) begin
      applyStimulus('0, 1'b0, 1'b0);
      checkOutput("idle_busy", busy_o, 0);
    end

    // Two grants at once, then the leftover
    $display("[TB] pulse 881");
    applyStimulus(12'h881, 1'b1, 1'b1);
    checkOutput("t2_pend", pending_o, 12'h881);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("t2_g0", gnt0_idx_o, 12);
    checkOutput("t2_g1", gnt1_idx_o, 8);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("t2_g0b", gnt0_idx_o, 1);
    checkOutput("t2_v1b", gnt1_valid_o, 0);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("t2_pend_end", pending_o, 0);

    // Slot 0 stalled while slot 1 drains
    $display("[TB] slot0 stall");
    applyStimulus(12'h00F, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("t3_g0a", gnt0_idx_o, 4);
    checkOutput("t3_g1a", gnt1_idx_o, 3);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("t3_g0b", gnt0_idx_o, 4);
    checkOutput("t3_g1b", gnt1_idx_o, 2);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("t3_g0c", gnt0_idx_o, 4);
    checkOutput("t3_g1c", gnt1_idx_o, 1);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("t3_v1d", gnt1_valid_o, 0);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("t3_v0e", gnt0_valid_o, 0);

    // Re-request of an index on the cycle it loads
    $display("[TB] re-request while loading");
    applyStimulus(12'h020, 1'b1, 1'b1);
    applyStimulus(12'h020, 1'b1, 1'b1);
    checkOutput("t4_g0", gnt0_idx_o, 6);
    checkOutput("t4_pend", pending_o, 12'h020);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("t4_g0again", gnt0_idx_o, 6);
    checkOutput("t4_v0again", gnt0_valid_o, 1);
    checkOutput("t4_pend_end", pending_o, 0);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("t4_grants", grants, newReqs);

    // Reset in the middle of a burst
    $display("[TB] reset mid-burst");
    applyStimulus(12'hFFF, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("t5_g0", gnt0_idx_o, 12);
    checkOutput("t5_g1", gnt1_idx_o, 11);
    checkOutput("t5_pend", pending_o, 12'h3FF);
    #2;
    applyReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus('0, 1'b1, 1'b1);
      checkOutput("t5_post_v0", gnt0_valid_o, 0);
      checkOutput("t5_post_v1", gnt1_valid_o, 0);
    end

    // Random traffic followed by a bounded drain
    $display("[TB] random traffic");
    for (int i = 0; i < 10000; i++) begin
      logic [11:0] p;
      p = ($urandom_range(0, 3) == 0) ? (12'($urandom) & 12'($urandom)) : 12'h000;
      applyStimulus(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 200 && (busy_o || m_v0 || m_v1 || m_pend != 0); c++) begin
      applyStimulus('0, 1'b1, 1'b1);
    end
    checkOutput("drain_busy", busy_o, 0);
    checkOutput("drain_q0", q0.size(), 0);
    checkOutput("drain_q1", q1.size(), 0);
    checkOutput("grant_count", grants, newReqs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
